imem_fetch: RTL

IMEM_FETCH -- requirements
Module: imem_fetch

---
 rtl/imem_fetch.sv | 123 ++++++++++++
 1 files changed

// File: rtl/imem_fetch.sv
// rtl/imem_fetch.sv - instruction memory with a fixed-latency fetch handshake and fault detection
// Optional program-write port is enabled by defining IMEM_PROG_EN.
module imem_fetch #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 32,
  parameter int                LATENCY   = 1,
  parameter logic [DATA_W-1:0] NOP_WORD  = '0,
  parameter string             INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [31:0]       req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_inst,
  output logic              rsp_fault,
  input  logic              flush
`ifdef IMEM_PROG_EN
  ,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
    $error("imem_fetch: LATENCY must be in 1..7");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [2:0]        cnt, cnt_d;
  logic [31:0]       addr_q;
  logic              load_addr;
  logic              load_rsp;
  logic              addr_fault;
  logic [ADDR_W-1:0] word_idx;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = NOP_WORD;
    end
  end

`ifdef IMEM_PROG_EN
  // Non-blocking write: a read registered on the same edge sees the old word.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end
`endif

  assign word_idx   = addr_q[ADDR_W+1:2];
  assign addr_fault = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_W + 2)) != 32'd0);

  assign req_ready = (state == IDLE) && !flush && rst_n;
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    load_addr = 1'b0;
    load_rsp  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !flush) begin
          state_d   = WAIT;
          cnt_d     = 3'(LATENCY - 1);
          load_addr = 1'b1;
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt != 3'd0) begin
          cnt_d = cnt - 3'd1;
        end else begin
          load_rsp = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (flush || rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      addr_q    <= 32'd0;
      rsp_inst  <= NOP_WORD;
      rsp_fault <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (load_addr) begin
        addr_q <= req_addr;
      end
      if (load_rsp) begin
        rsp_fault <= addr_fault;
        rsp_inst  <= addr_fault ? NOP_WORD : mem[word_idx];
      end
    end
  end

endmodule
